// File: rtl/cpu_bus_pkg.sv
// Shared types and width defaults for the CPU memory-port arbiter.
package cpu_bus_pkg;

    localparam int CPU_AW = 32;
    localparam int CPU_DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Ack watchdog: counts enabled cycles since the last clear; expire_o flags
// the cycle in which the TIMEOUT-th enabled cycle is being spent.
module mem_arb_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data memory, one
// transaction outstanding. Define ARB_ROUND_ROBIN_EN for round-robin ties.
module mem_port_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int AW      = CPU_AW,
    parameter int DW      = CPU_DW,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [DW/8-1:0] dm_be,
    input  logic [AW-1:0]   dm_addr,
    input  logic [DW-1:0]   dm_wdata,
    output logic            dm_gnt,
    output logic            dm_rvalid,
    output logic [DW-1:0]   dm_rdata,
    output logic            rsp_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_ack,
    input  logic [DW-1:0]   mem_rdata,
    output arb_state_t      dbg_state
);

    localparam int BW = DW / 8;

    // Handshake: a requester holds req and its fields until its gnt pulse;
    // mem_req is held until mem_ack or expiry; *_rvalid is a one-cycle pulse
    // to the owner, with rsp_err qualifying it.
    arb_state_t          state_q, state_d;
    owner_t              owner_q, owner_d;
    owner_t              last_q, last_d;
    logic                we_q, we_d;
    logic [BW-1:0]       be_q, be_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic [DW-1:0]       rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                pick_dm;
    logic                wd_expire;

    mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (state_q != BUSY),
        .en_i     (state_q == BUSY),
        .expire_o (wd_expire)
    );

    always_comb begin
        pick_dm = dm_req;
        if (dm_req && if_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            pick_dm = (last_q == OWN_IF);
`else
            pick_dm = 1'b1;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if_gnt  = 1'b0;
        dm_gnt  = 1'b0;
        case (state_q)
            IDLE: begin
                // Grants are combinational, so they must also be held off while rst is high.
                if (!rst && (if_req || dm_req)) begin
                    state_d = BUSY;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (pick_dm) begin
                        dm_gnt  = 1'b1;
                        owner_d = OWN_DM;
                        last_d  = OWN_DM;
                        we_d    = dm_we;
                        be_d    = dm_be;
                        addr_d  = dm_addr;
                        wdata_d = dm_wdata;
                    end else begin
                        if_gnt  = 1'b1;
                        owner_d = OWN_IF;
                        last_d  = OWN_IF;
                        we_d    = 1'b0;
                        be_d    = '1;
                        addr_d  = if_addr;
                        wdata_d = '0;
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_d = RESP;
                    rdata_d = we_q ? '0 : mem_rdata;
                    err_d   = 1'b0;
                end else if (wd_expire) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            last_q  <= OWN_IF;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign mem_req   = (state_q == BUSY);
    assign mem_we    = we_q;
    assign mem_be    = be_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_rvalid = (state_q == RESP) && (owner_q == OWN_IF);
    assign dm_rvalid = (state_q == RESP) && (owner_q == OWN_DM);
    assign if_rdata  = if_rvalid ? rdata_q : '0;
    assign dm_rdata  = dm_rvalid ? rdata_q : '0;
    assign rsp_err   = (state_q == RESP) && err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus timeout and reset sequences.
module tb_mem_port_arbiter;
    import cpu_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        rsp_err, mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    arb_state_t  dbg_state;

    int n_checks = 0;
    int n_err    = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [3:0]  dm_be;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic        mem_ack;
        logic [31:0] mem_rdata;
        logic        x_if_gnt;
        logic        x_if_rvalid;
        logic [31:0] x_if_rdata;
        logic        x_dm_gnt;
        logic        x_dm_rvalid;
        logic [31:0] x_dm_rdata;
        logic        x_err;
        logic        x_mem_req;
        logic        chk_mem;
        logic        x_we;
        logic [3:0]  x_be;
        logic [31:0] x_addr;
        logic [31:0] x_wdata;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl[NV];
    vec_t v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t d);
        if_req    = d.if_req;
        if_addr   = d.if_addr;
        dm_req    = d.dm_req;
        dm_we     = d.dm_we;
        dm_be     = d.dm_be;
        dm_addr   = d.dm_addr;
        dm_wdata  = d.dm_wdata;
        mem_ack   = d.mem_ack;
        mem_rdata = d.mem_rdata;
    endtask

    task automatic check_out(input string tag, input vec_t e);
        chk({tag, ".if_gnt"},    {31'd0, if_gnt},    {31'd0, e.x_if_gnt});
        chk({tag, ".if_rvalid"}, {31'd0, if_rvalid}, {31'd0, e.x_if_rvalid});
        chk({tag, ".if_rdata"},  if_rdata,           e.x_if_rdata);
        chk({tag, ".dm_gnt"},    {31'd0, dm_gnt},    {31'd0, e.x_dm_gnt});
        chk({tag, ".dm_rvalid"}, {31'd0, dm_rvalid}, {31'd0, e.x_dm_rvalid});
        chk({tag, ".dm_rdata"},  dm_rdata,           e.x_dm_rdata);
        chk({tag, ".rsp_err"},   {31'd0, rsp_err},   {31'd0, e.x_err});
        chk({tag, ".mem_req"},   {31'd0, mem_req},   {31'd0, e.x_mem_req});
        if (e.chk_mem) begin
            chk({tag, ".mem_we"},    {31'd0, mem_we}, {31'd0, e.x_we});
            chk({tag, ".mem_be"},    {28'd0, mem_be}, {28'd0, e.x_be});
            chk({tag, ".mem_addr"},  mem_addr,        e.x_addr);
            chk({tag, ".mem_wdata"}, mem_wdata,       e.x_wdata);
        end
    endtask

    // Called just after a rising edge: apply inputs, check mid-cycle, advance.
    task automatic cycle(input string tag, input vec_t d);
        drive(d);
        @(negedge clk);
        check_out(tag, d);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // IF read 0x100
        tbl[0]  = '{if_req:1'b1, if_addr:32'h100, x_if_gnt:1'b1, default:0};
        tbl[1]  = '{mem_ack:1'b1, mem_rdata:32'hDEADBEEF, x_mem_req:1'b1, chk_mem:1'b1, x_be:4'hF, x_addr:32'h100, default:0};
        tbl[2]  = '{x_if_rvalid:1'b1, x_if_rdata:32'hDEADBEEF, default:0};
        // IF and DM together: DM first, IF waits through BUSY/RESP
        tbl[3]  = '{if_req:1'b1, if_addr:32'h104, dm_req:1'b1, dm_be:4'hF, dm_addr:32'h2000, x_dm_gnt:1'b1, default:0};
        tbl[4]  = '{if_req:1'b1, if_addr:32'h104, mem_ack:1'b1, mem_rdata:32'h55AA1234, x_mem_req:1'b1, chk_mem:1'b1, x_be:4'hF, x_addr:32'h2000, default:0};
        tbl[5]  = '{if_req:1'b1, if_addr:32'h104, x_dm_rvalid:1'b1, x_dm_rdata:32'h55AA1234, default:0};
        tbl[6]  = '{if_req:1'b1, if_addr:32'h104, x_if_gnt:1'b1, default:0};
        tbl[7]  = '{x_mem_req:1'b1, chk_mem:1'b1, x_be:4'hF, x_addr:32'h104, default:0};
        tbl[8]  = '{mem_ack:1'b1, mem_rdata:32'h0BADF00D, x_mem_req:1'b1, default:0};
        tbl[9]  = '{x_if_rvalid:1'b1, x_if_rdata:32'h0BADF00D, default:0};
        // DM write with partial byte enables
        tbl[10] = '{dm_req:1'b1, dm_we:1'b1, dm_be:4'b0011, dm_addr:32'h3000, dm_wdata:32'h1234ABCD, x_dm_gnt:1'b1, default:0};
        tbl[11] = '{x_mem_req:1'b1, chk_mem:1'b1, x_we:1'b1, x_be:4'b0011, x_addr:32'h3000, x_wdata:32'h1234ABCD, default:0};
        tbl[12] = '{x_mem_req:1'b1, chk_mem:1'b1, x_we:1'b1, x_be:4'b0011, x_addr:32'h3000, x_wdata:32'h1234ABCD, default:0};
        tbl[13] = '{mem_ack:1'b1, mem_rdata:32'hFFFFFFFF, x_mem_req:1'b1, chk_mem:1'b1, x_we:1'b1, x_be:4'b0011, x_addr:32'h3000, x_wdata:32'h1234ABCD, default:0};
        tbl[14] = '{x_dm_rvalid:1'b1, x_dm_rdata:32'h0, default:0};
        // Spurious acks in IDLE and RESP
        tbl[15] = '{mem_ack:1'b1, mem_rdata:32'h77, default:0};
        tbl[16] = '{default:0};
        tbl[17] = '{if_req:1'b1, if_addr:32'h200, x_if_gnt:1'b1, default:0};
        tbl[18] = '{mem_ack:1'b1, mem_rdata:32'h11112222, x_mem_req:1'b1, chk_mem:1'b1, x_be:4'hF, x_addr:32'h200, default:0};
        tbl[19] = '{mem_ack:1'b1, mem_rdata:32'h99, x_if_rvalid:1'b1, x_if_rdata:32'h11112222, default:0};
        tbl[20] = '{mem_ack:1'b1, mem_rdata:32'h99, default:0};
        tbl[21] = '{default:0};

        // Reset with requests pending: everything must stay quiet
        rst = 1'b1;
        v = '{if_req:1'b1, dm_req:1'b1, dm_addr:32'h8, if_addr:32'h4, mem_ack:1'b1, default:0};
        drive(v);
        repeat (2) @(posedge clk);
        @(negedge clk);
        v = '{default:0};
        check_out("reset", v);
        chk("reset.state", {30'd0, dbg_state}, {30'd0, IDLE});
        drive(v);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            cycle($sformatf("vec%0d", i), tbl[i]);
        end

        // No ack: 16 BUSY cycles, then an error response
        v = '{dm_req:1'b1, dm_be:4'hF, dm_addr:32'h4000, mem_rdata:32'hAAAA5555, x_dm_gnt:1'b1, default:0};
        cycle("to_gnt", v);
        for (int i = 0; i < 16; i++) begin
            v = '{mem_rdata:32'hAAAA5555, x_mem_req:1'b1, chk_mem:1'b1, x_be:4'hF, x_addr:32'h4000, default:0};
            cycle($sformatf("to_busy%0d", i), v);
        end
        v = '{mem_rdata:32'hAAAA5555, x_dm_rvalid:1'b1, x_err:1'b1, x_dm_rdata:32'h0, default:0};
        cycle("to_resp", v);
        v = '{default:0};
        cycle("to_idle", v);

        // Ack in the 16th BUSY cycle wins over expiry
        v = '{dm_req:1'b1, dm_be:4'hF, dm_addr:32'h4400, x_dm_gnt:1'b1, default:0};
        cycle("ack16_gnt", v);
        for (int i = 0; i < 15; i++) begin
            v = '{x_mem_req:1'b1, default:0};
            cycle($sformatf("ack16_busy%0d", i), v);
        end
        v = '{mem_ack:1'b1, mem_rdata:32'hCAFE0001, x_mem_req:1'b1, default:0};
        cycle("ack16_ack", v);
        v = '{x_dm_rvalid:1'b1, x_dm_rdata:32'hCAFE0001, default:0};
        cycle("ack16_resp", v);

        // Reset in the middle of BUSY
        v = '{if_req:1'b1, if_addr:32'h300, x_if_gnt:1'b1, default:0};
        cycle("rstmid_gnt", v);
        v = '{if_req:1'b1, if_addr:32'h304, default:0};
        drive(v);
        chk("rstmid.busy_mem_req", {31'd0, mem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        v = '{default:0};
        check_out("rstmid.async", v);
        chk("rstmid.state", {30'd0, dbg_state}, {30'd0, IDLE});
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle("rstmid_q0", v);
        cycle("rstmid_q1", v);
        v = '{if_req:1'b1, if_addr:32'h500, x_if_gnt:1'b1, default:0};
        cycle("rstmid_new_gnt", v);
        v = '{mem_ack:1'b1, mem_rdata:32'h600DCAFE, x_mem_req:1'b1, chk_mem:1'b1, x_be:4'hF, x_addr:32'h500, default:0};
        cycle("rstmid_new_ack", v);
        v = '{x_if_rvalid:1'b1, x_if_rdata:32'h600DCAFE, default:0};
        cycle("rstmid_new_resp", v);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
